// File: rtl/bch_pkg.sv
// bch_pkg: shared GF(2^4) constants, FSM encoding and multiply helper for the BCH(15,7) decoder stages
package bch_pkg;
  localparam int GF_M = 4;
  localparam int CW_LEN = 15;
  localparam logic [4:0] PRIM_POLY = 5'b10011;
  localparam logic [GF_M-1:0] ALPHA_INV = 4'b1001;
  localparam logic [GF_M-1:0] ALPHA_INV2 = 4'b1101;
  typedef enum logic [1:0] {IDLE, SEARCH, DONE} state_t;
  function automatic logic [GF_M-1:0] gf_mul(input logic [GF_M-1:0] a, input logic [GF_M-1:0] b);
    logic [GF_M-1:0] p;
    logic [GF_M-1:0] x;
    p = '0;
    x = a;
    for (int i = 0; i < GF_M; i++) begin
      if (b[i]) p ^= x;
      x = {x[GF_M-2:0], 1'b0} ^ (x[GF_M-1] ? PRIM_POLY[GF_M-1:0] : '0);
    end
    return p;
  endfunction
endpackage

// File: rtl/gf16_const_mul.sv
// gf16_const_mul: combinational GF(2^4) multiply of a by constant C
// ports: a (4-bit operand) -> p (a*C)
module gf16_const_mul
  import bch_pkg::*;
#(
  parameter logic [GF_M-1:0] C = 4'b0001
) (
  input  logic [GF_M-1:0] a,
  output logic [GF_M-1:0] p
);
  assign p = gf_mul(a, C);
endmodule

// File: rtl/bch_chien_search.sv
// bch_chien_search: serial Chien search for BCH(15,7) t=2, one codeword position per clock
// ports: clk, rst (async active-low); start/lambda1/lambda2/rx_word in;
// busy, done (1-cycle), err_mask, corrected, err_count, uncorrectable out
module bch_chien_search
  import bch_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [GF_M-1:0]   lambda1,
  input  logic [GF_M-1:0]   lambda2,
  input  logic [CW_LEN-1:0] rx_word,
  output logic              busy,
  output logic              done,
  output logic [CW_LEN-1:0] err_mask,
  output logic [CW_LEN-1:0] corrected,
  output logic [1:0]        err_count,
  output logic              uncorrectable
);
  state_t state, nxt;
  logic [GF_M-1:0] r1, r2, r1_n, r2_n;
  logic [3:0] k;
  logic [CW_LEN-1:0] rx, mask, mask_n;
  logic [1:0] cnt, cnt_n, deg;
  logic hit, last, unc_n;
  gf16_const_mul #(.C(ALPHA_INV)) u_mul1 (.a(r1), .p(r1_n));
  gf16_const_mul #(.C(ALPHA_INV2)) u_mul2 (.a(r2), .p(r2_n));
  assign hit = (4'b0001 ^ r1 ^ r2) == '0;
  assign last = k == 4'd14;
  // final-position results are folded in combinationally so outputs are valid in the DONE cycle
  always_comb begin
    mask_n = mask | (hit ? CW_LEN'(1) << k : '0);
    cnt_n = (hit && cnt != 2'd3) ? cnt + 2'd1 : cnt;
    unc_n = cnt_n != deg;
  end
  always_comb begin
    nxt = state;
    if (state == IDLE && start) nxt = SEARCH;
    else if (state == SEARCH && last) nxt = DONE;
    else if (state == DONE) nxt = IDLE;
  end
  always_ff @(posedge clk or negedge rst)
    if (!rst) state <= IDLE;
    else state <= nxt;
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r1 <= '0;
      r2 <= '0;
      k <= '0;
      rx <= '0;
      mask <= '0;
      cnt <= '0;
      deg <= '0;
      busy <= 1'b0;
      done <= 1'b0;
      err_mask <= '0;
      corrected <= '0;
      err_count <= '0;
      uncorrectable <= 1'b0;
    end else begin
      done <= 1'b0;
      if (state == IDLE && start) begin
        r1 <= lambda1;
        r2 <= lambda2;
        rx <= rx_word;
        k <= '0;
        mask <= '0;
        cnt <= '0;
        deg <= lambda2 != '0 ? 2'd2 : lambda1 != '0 ? 2'd1 : 2'd0;
        busy <= 1'b1;
      end
      if (state == SEARCH) begin
        r1 <= r1_n;
        r2 <= r2_n;
        mask <= mask_n;
        cnt <= cnt_n;
        k <= last ? k : k + 4'd1;
        if (last) begin
          done <= 1'b1;
          busy <= 1'b0;
          err_mask <= mask_n;
          err_count <= cnt_n;
          uncorrectable <= unc_n;
          corrected <= unc_n ? rx : rx ^ mask_n;
        end
      end
    end
  end
endmodule

// File: doc/bch_chien_search.md
Name: bch_chien_search

Overview:
Downstream stage of the inversionless Berlekamp-Massey block (ibm_block) in the BCH(15,7), t=2 decoder over GF(2^4).
- Inputs: error-locator coefficients lambda1 and lambda2 (lambda0 = 1), plus the 15-bit received word.
- Operation: serial Chien search, one codeword position per clock. Produces the error mask, the corrected word, the error count and an uncorrectable flag.
- Output feeds the decoder output register / data sink.

Parameters:
CW_LEN, 15, codeword length n; only 15 is supported.
GF_M, 4, field width in bits; only 4 is supported.
PRIM_POLY, 5'b10011, primitive polynomial x^4+x+1.

Ports:
clk  input  1  system clock, rising edge.
rst  input  1  asynchronous, active-low reset (asserted when 0).
start  input  1  one-cycle request; samples lambda1, lambda2 and rx_word.
lambda1  input  4  locator coefficient of x (from ibm_block).
lambda2  input  4  locator coefficient of x^2 (from ibm_block).
rx_word  input  15  received codeword; bit k is the coefficient of x^k.
busy  output  1  high while a search is in progress.
done  output  1  one-cycle pulse; results are valid from this cycle.
err_mask  output  15  bit k = 1 means an error was located at position k.
corrected  output  15  rx_word XOR err_mask; equals rx_word when uncorrectable.
err_count  output  2  number of distinct roots found (0..2).
uncorrectable  output  1  root count differs from locator degree.

Behaviour:
- Reset (rst = 0, asynchronous): state IDLE. busy=0, done=0, err_mask=0, corrected=0, err_count=0, uncorrectable=0. Internal registers cleared.
- Reset asserted mid-search aborts the search immediately. No done is produced. After rst returns high the block sits in IDLE.
- FSM has three states:
  - IDLE: on start=1, capture inputs, r1 <= lambda1, r2 <= lambda2, k <= 0, clear the mask accumulator. Compute deg = 2 if lambda2 != 0; 1 if lambda2 == 0 and lambda1 != 0; else 0. Go to SEARCH, busy <= 1.
  - SEARCH: each cycle compute s = 1 ^ r1 ^ r2 in GF(2^4).
    - If s == 0: set mask bit k and increment the root count, saturating at 3 internally.
    - Then r1 <= r1*alpha^-1 (alpha^14 = 4'b1001), r2 <= r2*alpha^-2 (alpha^13 = 4'b1101), k <= k+1.
    - After k = 14 is evaluated, go to DONE.
  - DONE: register the outputs, done=1 for exactly one cycle, busy <= 0, return to IDLE.
- Output values registered in DONE:
  - err_mask = accumulated mask.
  - err_count = root count (2 bits).
  - uncorrectable = (count != deg).
  - corrected = uncorrectable ? rx : rx ^ mask.
- Latency: start sampled on edge E0. Positions 0..14 are evaluated on edges E1..E15. done is high in the cycle after E15. Next start is accepted the cycle after done.
- Outputs hold their last values until the next DONE, and are not cleared by start.
- start while busy=1 or done=1 is ignored; inputs are not re-sampled.
- deg = 0 (both lambdas zero): s is always 1, so no roots are found. Result is err_count=0, uncorrectable=0, corrected=rx_word.
- All GF arithmetic is 4-bit XOR/shift with reduction by PRIM_POLY. There is no carry and no width growth.
- k counter is 4 bits and never wraps past 14.

Decomposition:
- Shared package bch_pkg holds:
  - GF_M, CW_LEN, PRIM_POLY.
  - Constants ALPHA_INV = 4'b1001 and ALPHA_INV2 = 4'b1101.
  - FSM state encoding IDLE/SEARCH/DONE, also reused by the syndrome and ibm stages.
- One sub-module, gf16_const_mul: a combinational 4-bit multiply by a parameterised constant. Instantiated twice, for r1 and r2.

Test Plan:
- Single error: lambda1=4'b1000 (alpha^3), lambda2=0, rx=15'h0000, start. Expect done 15 cycles later, err_mask=15'h0008, corrected=15'h0008, err_count=1, uncorrectable=0.
- Double error: lambda1=4'b0010 (alpha), lambda2=4'b1011 (alpha^7), rx=15'h7FFF. Expect err_mask=15'h0024, corrected=15'h7FDB, err_count=2, uncorrectable=0.
- Double error: lambda1=4'b0001, lambda2=4'b0001, rx=15'h0000. Expect err_mask=15'h0420 (bits 5 and 10), err_count=2, uncorrectable=0.
- Uncorrectable: lambda1=0, lambda2=4'b0001 (1+x^2, double root). Expect err_mask=15'h0001, err_count=1, uncorrectable=1, corrected=rx unchanged.
- No error: lambda1=0, lambda2=0, rx=15'h1234. Expect err_mask=0, err_count=0, uncorrectable=0, corrected=15'h1234.
- Control: start pulsed during SEARCH is ignored; done comes at the original cycle with the original result. rst=0 at search cycle 7 clears all outputs with no done. A subsequent start completes normally.
